// File: rtl/vec_mem_access.sv
// Four-lane vector load/store sequencer: one memory access per cycle, lane address = base + lane*LANE_STRIDE.
// Optional alignment rejection when VEC_MEM_ALIGN_CHECK_EN is defined (misalign pulse instead of an access).
module vec_mem_access #(
  parameter int LANE_STRIDE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_mem_in,
  input  logic        rd_mem_in,
  input  logic [31:0] store_address_in,
  input  logic [31:0] v1in,
  input  logic [31:0] v2in,
  input  logic [31:0] v3in,
  input  logic [31:0] v4in,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  output logic [31:0] ld1out,
  output logic [31:0] ld2out,
  output logic [31:0] ld3out,
  output logic [31:0] ld4out,
  output logic        stall,
  output logic        done,
  output logic        misalign
);

  typedef enum logic [2:0] {S_IDLE, S_STORE, S_LOAD, S_DRAIN, S_FINISH} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] base_q, base_d;
  logic [31:0] vd_q [4];
  logic [31:0] vd_d [4];
  logic [31:0] ld_q [4];
  logic [31:0] ld_d [4];
  logic        rd_pend_q, rd_pend_d;
  logic [1:0]  rd_lane_q, rd_lane_d;
  logic        misalign_q, misalign_d;
  logic        req;
  logic        req_bad;
  logic [31:0] lane_addr;

  assign req       = wr_mem_in | rd_mem_in;
  assign lane_addr = base_q + 32'(cnt_q) * 32'(LANE_STRIDE);

`ifdef VEC_MEM_ALIGN_CHECK_EN
  assign req_bad = store_address_in[1:0] != 2'b00;
`else
  assign req_bad = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    base_d     = base_q;
    vd_d       = vd_q;
    ld_d       = ld_q;
    rd_pend_d  = 1'b0;
    rd_lane_d  = rd_lane_q;
    misalign_d = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_addr   = 32'h0;
    mem_wdata  = 32'h0;
    stall      = 1'b0;
    done       = 1'b0;

    // Read data returns one cycle after its strobe; land it in the lane that issued it.
    if (rd_pend_q) ld_d[rd_lane_q] = mem_rdata;

    case (state_q)
      S_IDLE: begin
        if (req && req_bad) begin
          misalign_d = 1'b1;
        end else if (req) begin
          stall   = 1'b1;
          base_d  = store_address_in;
          vd_d    = '{v1in, v2in, v3in, v4in};
          cnt_d   = 2'd0;
          state_d = wr_mem_in ? S_STORE : S_LOAD;
        end
      end
      S_STORE: begin
        stall     = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = lane_addr;
        mem_wdata = vd_q[cnt_q];
        cnt_d     = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = S_FINISH;
      end
      S_LOAD: begin
        stall     = 1'b1;
        mem_re    = 1'b1;
        mem_addr  = lane_addr;
        rd_pend_d = 1'b1;
        rd_lane_d = cnt_q;
        cnt_d     = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        stall   = 1'b1;
        state_d = S_FINISH;
      end
      S_FINISH: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 2'd0;
      base_q     <= 32'h0;
      vd_q       <= '{default: 32'h0};
      ld_q       <= '{default: 32'h0};
      rd_pend_q  <= 1'b0;
      rd_lane_q  <= 2'd0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      base_q     <= base_d;
      vd_q       <= vd_d;
      ld_q       <= ld_d;
      rd_pend_q  <= rd_pend_d;
      rd_lane_q  <= rd_lane_d;
      misalign_q <= misalign_d;
    end
  end

  assign ld1out   = ld_q[0];
  assign ld2out   = ld_q[1];
  assign ld3out   = ld_q[2];
  assign ld4out   = ld_q[3];
  assign misalign = misalign_q;

endmodule

// File: tb/tb_vec_mem_access.sv
// Scoreboard bench for vec_mem_access: drivers push expected memory/done/misalign events, a negedge monitor pops and compares.
module tb_vec_mem_access;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_mem_in = 1'b0;
  logic        rd_mem_in = 1'b0;
  logic [31:0] store_address_in = 32'h0;
  logic [31:0] v1in = 32'h0, v2in = 32'h0, v3in = 32'h0, v4in = 32'h0;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_we, mem_re;
  logic [31:0] ld1out, ld2out, ld3out, ld4out;
  logic        stall, done, misalign;

  vec_mem_access #(.LANE_STRIDE(4)) dut (
    .clk(clk), .reset(reset), .wr_mem_in(wr_mem_in), .rd_mem_in(rd_mem_in),
    .store_address_in(store_address_in), .v1in(v1in), .v2in(v2in), .v3in(v3in), .v4in(v4in),
    .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .ld1out(ld1out), .ld2out(ld2out),
    .ld3out(ld3out), .ld4out(ld4out), .stall(stall), .done(done), .misalign(misalign)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] K_WE = 3'd1, K_RE = 3'd2, K_DONE = 3'd3, K_MIS = 3'd4;

  typedef struct packed {
    logic [2:0]       kind;
    logic [31:0]      cyc;
    logic [31:0]      addr;
    logic [31:0]      data;
    logic [3:0][31:0] ld;
  } ev_t;

  ev_t              exp_q[$];
  logic [3:0][31:0] exp_ld = '0;
  int               errors = 0;
  int               checks = 0;
  int               cyc = 0;
  int               t_req;
  logic [31:0]      rd_pipe = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_lookup(input logic [31:0] a);
    case (a)
      32'h200: return 32'h0000000A;
      32'h204: return 32'h0000000B;
      32'h208: return 32'h0000000C;
      32'h20C: return 32'h0000000D;
      32'h500: return 32'h11111111;
      32'h504: return 32'h22222222;
      32'h508: return 32'h33333333;
      32'h50C: return 32'h44444444;
      default: return 32'hDEAD0000 | {16'h0, a[15:0]};
    endcase
  endfunction

  // One-cycle read latency memory model.
  always @(negedge clk) begin
    mem_rdata = rd_pipe;
    rd_pipe   = mem_re ? mem_lookup(mem_addr) : 32'h0;
  end

  task automatic push(input logic [2:0] kind, input int c, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    e.kind = kind;
    e.cyc  = 32'(c);
    e.addr = a;
    e.data = d;
    e.ld   = exp_ld;
    exp_q.push_back(e);
  endtask

  function automatic ev_t pop_or_missing(input logic [2:0] kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      e = '0;
      e.kind = 3'd0;
    end else begin
      e = exp_q.pop_front();
    end
    return e;
  endfunction

  always @(negedge clk) begin
    ev_t e;
    if (!reset) begin
      if (mem_we || mem_re) begin
        chk("strobe_exclusive", {31'h0, mem_we & mem_re}, 32'h0);
        chk("stall_busy", {31'h0, stall}, 32'h1);
        e = pop_or_missing(K_WE);
        chk("strobe_kind", {29'h0, mem_we ? K_WE : K_RE}, {29'h0, e.kind});
        chk("strobe_cycle", 32'(cyc), e.cyc);
        chk("mem_addr", mem_addr, e.addr);
        if (mem_we) chk("mem_wdata", mem_wdata, e.data);
      end else begin
        chk("idle_addr_wdata", mem_addr | mem_wdata, 32'h0);
      end
      if (done) begin
        e = pop_or_missing(K_DONE);
        chk("done_kind", {29'h0, K_DONE}, {29'h0, e.kind});
        chk("done_cycle", 32'(cyc), e.cyc);
        chk("done_stall", {31'h0, stall}, 32'h0);
        chk("ld1out", ld1out, e.ld[0]);
        chk("ld2out", ld2out, e.ld[1]);
        chk("ld3out", ld3out, e.ld[2]);
        chk("ld4out", ld4out, e.ld[3]);
      end
      if (misalign) begin
        e = pop_or_missing(K_MIS);
        chk("misalign_kind", {29'h0, K_MIS}, {29'h0, e.kind});
        chk("misalign_cycle", 32'(cyc), e.cyc);
      end
    end
  end

  task automatic issue(input logic wr, input logic rd, input logic [31:0] base,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                       input logic [31:0] d, input logic exp_stall);
    @(posedge clk) #1;
    wr_mem_in = wr; rd_mem_in = rd; store_address_in = base;
    v1in = a; v2in = b; v3in = c; v4in = d;
    t_req = cyc;
    #1 chk("req_stall", {31'h0, stall}, {31'h0, exp_stall});
  endtask

  task automatic release_req();
    @(posedge clk) #1;
    wr_mem_in = 1'b0; rd_mem_in = 1'b0;
    store_address_in = 32'h0; v1in = 32'h0; v2in = 32'h0; v3in = 32'h0; v4in = 32'h0;
  endtask

  task automatic push_store(input logic [31:0] base, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic [31:0] d);
    push(K_WE, t_req + 1, base,          a);
    push(K_WE, t_req + 2, base + 32'd4,  b);
    push(K_WE, t_req + 3, base + 32'd8,  c);
    push(K_WE, t_req + 4, base + 32'd12, d);
    push(K_DONE, t_req + 5, 32'h0, 32'h0);
  endtask

  task automatic store_op(input logic both, input logic [31:0] base, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
    issue(1'b1, both, base, a, b, c, d, 1'b1);
    push_store(base, a, b, c, d);
    release_req();
    repeat (4) @(posedge clk);
  endtask

  task automatic load_op(input logic [31:0] base, input logic [31:0] e0, input logic [31:0] e1,
                         input logic [31:0] e2, input logic [31:0] e3);
    issue(1'b0, 1'b1, base, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    for (int k = 0; k < 4; k++) push(K_RE, t_req + 1 + k, base + 32'(4 * k), 32'h0);
    exp_ld = {e3, e2, e1, e0};
    push(K_DONE, t_req + 6, 32'h0, 32'h0);
    release_req();
    repeat (5) @(posedge clk);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ld", ld1out | ld2out | ld3out | ld4out, 32'h0);
    chk("rst_flags", {28'h0, done, misalign, mem_we, mem_re}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    reset = 1'b0;

    store_op(1'b0, 32'h100, 32'd1, 32'd2, 32'd3, 32'd4);
    load_op(32'h200, 32'hA, 32'hB, 32'hC, 32'hD);
    store_op(1'b0, 32'hFFFFFFF8, 32'd5, 32'd6, 32'd7, 32'd8);
    store_op(1'b1, 32'h300, 32'h9, 32'hA, 32'hB, 32'hC);

    // Requests raised while a store is in progress must be ignored.
    issue(1'b1, 1'b0, 32'h400, 32'h41, 32'h42, 32'h43, 32'h44, 1'b1);
    push_store(32'h400, 32'h41, 32'h42, 32'h43, 32'h44);
    release_req();
    @(posedge clk) #1;
    wr_mem_in = 1'b1; rd_mem_in = 1'b1; store_address_in = 32'h999;
    @(posedge clk) #1;
    wr_mem_in = 1'b0; rd_mem_in = 1'b0; store_address_in = 32'h0;
    repeat (2) @(posedge clk);

    load_op(32'h500, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);

    // Reset during the third cycle of a load abandons it.
    issue(1'b0, 1'b1, 32'h200, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    push(K_RE, t_req + 1, 32'h200, 32'h0);
    release_req();
    @(posedge clk) #1;
    reset = 1'b1;
    @(posedge clk) #1;
    reset = 1'b0;
    chk("abort_ld", ld1out | ld2out | ld3out | ld4out, 32'h0);
    chk("abort_flags", {28'h0, done, misalign, mem_we, mem_re}, 32'h0);
    chk("abort_stall", {31'h0, stall}, 32'h0);
    exp_ld = '0;
    repeat (3) @(posedge clk);
    chk("abort_no_events", 32'(exp_q.size()), 32'h0);

    store_op(1'b0, 32'h600, 32'h61, 32'h62, 32'h63, 32'h64);

`ifdef VEC_MEM_ALIGN_CHECK_EN
    issue(1'b1, 1'b0, 32'h102, 32'd1, 32'd2, 32'd3, 32'd4, 1'b0);
    push(K_MIS, t_req + 1, 32'h0, 32'h0);
    release_req();
    repeat (5) @(posedge clk);
    store_op(1'b0, 32'h700, 32'h71, 32'h72, 32'h73, 32'h74);
`else
    store_op(1'b0, 32'h102, 32'd1, 32'd2, 32'd3, 32'd4);
`endif

    repeat (4) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vec_mem_access.md
VEC_MEM_ACCESS -- requirements
Module: vec_mem_access

Interface
REQ-001 Parameter LANE_STRIDE, default 4, byte address increment between consecutive vector lanes.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 wr_mem_in  in  1  vector store request from EX/MEM register.
REQ-005 rd_mem_in  in  1  vector load request from EX/MEM register.
REQ-006 store_address_in  in  32  base byte address of lane 0.
REQ-007 v1in, v2in, v3in, v4in  in  32 each  store data for lanes 0..3.
REQ-008 mem_rdata  in  32  memory read data, valid one cycle after mem_re.
REQ-009 mem_addr  out  32  memory address.
REQ-010 mem_wdata  out  32  memory write data.
REQ-011 mem_we, mem_re  out  1 each  memory write / read strobes.
REQ-012 ld1out, ld2out, ld3out, ld4out  out  32 each  loaded lanes 0..3.
REQ-013 stall  out  1  combinational hold request to upstream stages.
REQ-014 done  out  1  one-cycle pulse on operation completion.
REQ-015 misalign  out  1  one-cycle pulse on rejected misaligned request.

Function
REQ-016 FSM states IDLE, STORE, LOAD, DRAIN, FINISH; 2-bit lane counter; lane address = base + lane*LANE_STRIDE, 32-bit wrap-around, no overflow flag.
REQ-017 IDLE, request high at cycle T: capture base and v1..v4, clear counter, go STORE (wr) or LOAD (rd); wr_mem_in wins when both high, load dropped.
REQ-018 STORE: mem_we=1, mem_wdata=lane data, one lane per cycle, lanes 0..3 at T+1..T+4; after lane 3 go FINISH.
REQ-019 LOAD: mem_re=1, reads issued lanes 0..3 at T+1..T+4; after lane 3 go DRAIN.
REQ-020 mem_rdata captured into ld(k+1)out the cycle after lane k issued; lane 3 captured in DRAIN (T+5); DRAIN goes FINISH.
REQ-021 ld1..ld4out hold value until next load writes them; stores never modify them.
REQ-022 FINISH: done=1 for exactly one cycle (store T+5, load T+6), no memory strobes, next state IDLE.
REQ-023 stall=1 when IDLE with accepted request, and in STORE, LOAD, DRAIN; stall=0 in FINISH and idle-without-request.
REQ-024 Requests arriving outside IDLE ignored; new request accepted in the cycle after FINISH.
REQ-025 mem_we, mem_re never both high; both low in IDLE, DRAIN, FINISH; mem_addr/mem_wdata 0 when strobes low.

Reset
REQ-026 reset high at any edge: state IDLE, counter 0, captured base/data 0, ld1..ld4out 0, done 0, misalign 0, strobes 0; in-flight operation abandoned, no done.
REQ-027 reset has priority over a simultaneous request.

Configuration
REQ-028 VEC_MEM_ALIGN_CHECK_EN defined: request with store_address_in[1:0] != 0 in IDLE rejected: misalign=1 next cycle for one cycle, no memory access, no done, stall=0, state stays IDLE.
REQ-029 VEC_MEM_ALIGN_CHECK_EN undefined: address used unmodified, misalign tied 0, port retained.

Verification
REQ-030 Store base 0x100, v=1,2,3,4 -> mem_we T+1..T+4, addr 0x100,0x104,0x108,0x10C, data 1..4; done at T+5; stall high T..T+4.
REQ-031 Load base 0x200, memory returns 0xA,0xB,0xC,0xD -> mem_re T+1..T+4; ld1..ld4out=0xA..0xD at T+6; done at T+6.
REQ-032 wr and rd high together -> store only, no mem_re for whole operation.
REQ-033 Reset asserted at T+2 of a load -> outputs 0 next cycle, no done; fresh store then completes normally.
REQ-034 Base 0xFFFFFFF8 store -> addrs 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
REQ-035 With VEC_MEM_ALIGN_CHECK_EN, store base 0x102 -> misalign pulse at T+1, no strobes, no done; without macro, writes at 0x102..0x10E.
